// File: rtl/rtc_regs_pkg.sv
// Shared register map and bank FSM encoding for the RTC time/date/timer register bank.
package rtc_regs_pkg;

  localparam int REG_SEC      = 0;
  localparam int REG_MIN      = 1;
  localparam int REG_HR       = 2;
  localparam int REG_DAY      = 3;
  localparam int REG_MONTH    = 4;
  localparam int REG_YEAR     = 5;
  localparam int REG_TMR_SEC  = 6;
  localparam int REG_TMR_MIN  = 7;
  localparam int REG_TMR_HR   = 8;
  localparam int NUM_RTC_REGS = 9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STAGED = 2'd1,
    ST_COMMIT = 2'd2
  } bank_state_e;

endpackage

// File: rtl/shadow_reg_bank.sv
// Shadow/active register bank: writes stage into a shadow copy, and a commit copies
// every shadow register into the active outputs on a single edge so readers never see torn fields.
module shadow_reg_bank
  import rtc_regs_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = NUM_RTC_REGS,
  parameter int ADDR_W   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         commit,
  input  logic                         discard,
  output logic                         commit_done,
  output logic                         wr_err,
  output logic [NUM_REGS-1:0]          dirty,
  input  logic [ADDR_W-1:0]            rd_addr,
  output logic [DATA_W-1:0]            rd_data,
  output logic [NUM_REGS*DATA_W-1:0]   active_flat
);

  bank_state_e r_state;
  bank_state_e w_state_nxt;

  logic                r_commit_done;
  logic                r_wr_err;
  logic [DATA_W-1:0]   r_rd_data;
  logic [DATA_W-1:0]   w_rd_mux;
  logic [DATA_W-1:0]   w_active [NUM_REGS];
  logic [NUM_REGS-1:0] w_wr_hit;
  logic                w_accept;
  logic                w_wr_in_range;
  logic                w_in_commit;
  logic                w_discard;

  assign w_in_commit   = (r_state == ST_COMMIT);
  assign wr_ready      = ~w_in_commit;
  assign w_accept      = wr_valid & wr_ready;
  assign w_wr_in_range = |w_wr_hit;
  // Commit beats discard when both arrive together.
  assign w_discard     = discard & ~commit;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    logic [DATA_W-1:0] r_shadow;
    logic [DATA_W-1:0] r_active;
    logic              r_dirty;

    assign w_wr_hit[i] = w_accept & (wr_addr == ADDR_W'(i));

    // NOTE: every storage element is cleared by reset; this bank is small flops, not a RAM macro,
    // so a reset value costs nothing and keeps active outputs defined from the first cycle.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_shadow <= '0;
        r_active <= '0;
        r_dirty  <= 1'b0;
      end else if (w_in_commit) begin
        r_active <= r_shadow;
        r_dirty  <= 1'b0;
      end else if (w_discard) begin
        r_shadow <= r_active;
        r_dirty  <= 1'b0;
      end else if (w_wr_hit[i]) begin
        r_shadow <= wr_data;
        r_dirty  <= 1'b1;
      end
    end

    assign w_active[i]                       = r_active;
    assign active_flat[i*DATA_W +: DATA_W]   = r_active;
    assign dirty[i]                          = r_dirty;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (commit)                          w_state_nxt = ST_COMMIT;
        else if (w_wr_in_range && !discard)  w_state_nxt = ST_STAGED;
      end
      ST_STAGED: begin
        if (commit)       w_state_nxt = ST_COMMIT;
        else if (discard) w_state_nxt = ST_IDLE;
      end
      ST_COMMIT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Out-of-range read addresses match no register and fall through to zero.
  always_comb begin
    w_rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == ADDR_W'(i)) w_rd_mux = w_active[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_commit_done <= 1'b0;
      r_wr_err      <= 1'b0;
      r_rd_data     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_commit_done <= w_in_commit;
      r_wr_err      <= w_accept & ~w_wr_in_range;
      r_rd_data     <= w_rd_mux;
    end
  end

  assign commit_done = r_commit_done;
  assign wr_err      = r_wr_err;
  assign rd_data     = r_rd_data;

endmodule
